// File: rtl/mux_sample_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mux_sample_arbiter                                            |
// | Purpose  : Round-robin arbiter and sequencer for a shared 2:1 sample     |
// |            mux. Selects a requester, holds the mux select for a settle   |
// |            window, captures the mux output, and presents it downstream   |
// |            with a valid/ready handshake and a source tag.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mux_sample_arbiter #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2    // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] mux_out,
  output logic              mux_sel,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  // Settle counter reload: SETTLE runs HOLD_CYCLES cycles, counting down to 0.
  localparam logic [3:0] c_cnt_init = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_last_grant;
  logic                r_mux_sel;
  logic                r_gnt0;
  logic                r_gnt1;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_src;
  logic                r_out_valid;
  logic                r_busy;

  logic                w_winner;
  logic                w_win_req;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  // The current winner is whatever the mux select points at during SETTLE.
  always_comb begin
    w_winner  = req1;
    if (req0 && req1) begin
      w_winner = ~r_last_grant;
    end
    w_win_req = r_mux_sel ? req1 : req0;
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_mux_sel    <= 1'b0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_out_data   <= '0;
      r_out_src    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Grants are single-cycle pulses.
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req0 || req1) begin
            r_mux_sel <= w_winner;
            r_cnt     <= c_cnt_init;
            r_state   <= ST_SETTLE;
            r_busy    <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!w_win_req) begin
            // Winner withdrew: abandon without touching grant history or output.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == 4'd0) begin
            r_out_data   <= mux_out;
            r_out_src    <= r_mux_sel;
            r_out_valid  <= 1'b1;
            r_gnt0       <= ~r_mux_sel;
            r_gnt1       <= r_mux_sel;
            r_last_grant <= r_mux_sel;
            r_state      <= ST_OUTPUT;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_OUTPUT: begin
          // Sample is held until accepted; new requests wait for IDLE.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign mux_sel   = r_mux_sel;
  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux_sample_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mux_sample_arbiter                                         |
// | Purpose  : Self-checking bench for mux_sample_arbiter: table vectors,    |
// |            random transactions against a transaction-level model, and    |
// |            hand sequences for tie streaming, async reset, HOLD=1.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mux_sample_arbiter;

  localparam int HOLD = 2;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] i0, i1;
  logic [7:0] mux_out;
  logic       mux_sel, gnt0, gnt1, out_src, out_valid, out_ready, busy;
  logic [7:0] out_data;

  // Second instance built with the shortest settle window.
  logic       b_req0, b_ready, b_sel, b_gnt0, b_gnt1, b_src, b_valid, b_busy;
  logic [7:0] b_i0, b_mux_out, b_data;

  int n_pass;
  int n_total;

  // Transaction-level model state.
  bit         m_last;
  logic [7:0] m_data;

  typedef struct {
    bit         r0;
    bit         r1;
    logic [7:0] v0;
    logic [7:0] v1;
    int         abort_at;   // 0 = no abort, k = drop request before k-th settle edge
    int         rdy;        // cycles of backpressure before out_ready
    bit         exp_src;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[8];

  // Real 2:1 mux behaviour so the captured data also proves the select.
  assign mux_out   = mux_sel ? i1 : i0;
  assign b_mux_out = b_sel ? 8'h00 : b_i0;

  mux_sample_arbiter #(.DATA_W(8), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .mux_out(mux_out),
    .mux_sel(mux_sel), .gnt0(gnt0), .gnt1(gnt1), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  mux_sample_arbiter #(.DATA_W(8), .HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst_n(rst_n), .req0(b_req0), .req1(1'b0), .mux_out(b_mux_out),
    .mux_sel(b_sel), .gnt0(b_gnt0), .gnt1(b_gnt1), .out_data(b_data),
    .out_src(b_src), .out_valid(b_valid), .out_ready(b_ready), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Runs one request from IDLE (called at a negedge) through capture and handshake.
  task automatic do_txn(input vec_t v, input string tag);
    i0 = v.v0; i1 = v.v1;
    req0 = v.r0; req1 = v.r1; out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_sel"}, mux_sel, v.exp_src);
    for (int j = 1; j <= HOLD; j++) begin
      if (v.abort_at == j) begin
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk({tag, "_abort_busy"}, busy, 0);
        chk({tag, "_abort_valid"}, out_valid, 0);
        chk({tag, "_abort_gnt"}, {gnt1, gnt0}, 0);
        chk({tag, "_abort_data"}, out_data, m_data);
        return;
      end
      @(negedge clk);
      if (j < HOLD) chk({tag, "_early_valid"}, out_valid, 0);
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, v.exp_data);
    chk({tag, "_src"}, out_src, v.exp_src);
    chk({tag, "_gnt"}, {gnt1, gnt0}, v.exp_src ? 2 : 1);
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < v.rdy; k++) begin
      // Requests during OUTPUT must be ignored.
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk({tag, "_bp_valid"}, out_valid, 1);
      chk({tag, "_bp_data"}, {out_src, out_data}, {v.exp_src, v.exp_data});
      chk({tag, "_bp_gnt"}, {gnt1, gnt0}, 0);
    end
    req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_hs_valid"}, out_valid, 0);
    chk({tag, "_hs_busy"}, busy, 0);
    chk({tag, "_hs_gnt"}, {gnt1, gnt0}, 0);
    chk({tag, "_hs_data"}, out_data, v.exp_data);
    out_ready = 1'b0;
    m_last = v.exp_src;
    m_data = v.exp_data;
  endtask

  initial begin
    int ng;
    vec_t rv;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; req0 = 0; req1 = 0; out_ready = 0; i0 = 0; i1 = 0;
    b_req0 = 0; b_ready = 0; b_i0 = 0;

    // Hand-derived vectors, HOLD=2, starting from reset (last grant = 1).
    tbl[0] = '{1, 0, 8'hA5, 8'h5A, 0, 0, 0, 8'hA5};  // single req0
    tbl[1] = '{1, 1, 8'h11, 8'h22, 0, 0, 1, 8'h22};  // tie after req0 -> req1
    tbl[2] = '{1, 1, 8'h11, 8'h22, 0, 1, 0, 8'h11};
    tbl[3] = '{1, 1, 8'h11, 8'h22, 0, 0, 1, 8'h22};
    tbl[4] = '{0, 1, 8'h00, 8'h3C, 0, 5, 1, 8'h3C};  // backpressure 5 cycles
    tbl[5] = '{1, 0, 8'h66, 8'h77, 0, 2, 0, 8'h66};
    tbl[6] = '{0, 1, 8'h99, 8'h88, 2, 0, 1, 8'h00};  // req1 aborts in SETTLE
    tbl[7] = '{1, 1, 8'h44, 8'h55, 0, 0, 1, 8'h55};  // tie still goes to req1

    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_sel_busy", {mux_sel, busy}, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_data_src", {out_src, out_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Continuous tie with out_ready high: grants must alternate from req0.
    i0 = 8'h11; i1 = 8'h22; req0 = 1; req1 = 1; out_ready = 1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("tie_src", out_src, ng % 2);
        chk("tie_data", out_data, (ng % 2) ? 8'h22 : 8'h11);
        chk("tie_gnt", {gnt1, gnt0}, (ng % 2) ? 2 : 1);
        ng++;
      end
    end
    chk("tie_count", ng, 4);
    req0 = 0; req1 = 0;
    @(negedge clk);
    out_ready = 0;
    @(negedge clk);
    chk("tie_end_busy", busy, 0);

    // Table vectors assume the last grant went to req1, which the tie run left.
    m_last = 1; m_data = 8'h22;
    for (int t = 0; t < 8; t++) begin
      do_txn(tbl[t], $sformatf("vec%0d", t));
      @(negedge clk);
    end

    // Randomized transactions against the round-robin model.
    for (int n = 0; n < 60; n++) begin
      int p;
      p = $urandom_range(1, 3);
      rv.r0 = p[0]; rv.r1 = p[1];
      rv.v0 = 8'($urandom); rv.v1 = 8'($urandom);
      rv.abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, HOLD)) : 0;
      rv.rdy = $urandom_range(0, 3);
      rv.exp_src = (rv.r0 && rv.r1) ? ~m_last : rv.r1;
      rv.exp_data = rv.exp_src ? rv.v1 : rv.v0;
      do_txn(rv, $sformatf("rnd%0d", n));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Async reset while a req1 sample is in OUTPUT.
    i0 = 8'hC3; i1 = 8'h3C; req0 = 0; req1 = 1; out_ready = 0;
    repeat (HOLD + 1) @(negedge clk);
    chk("ar_pre_valid", {out_valid, gnt1, mux_sel}, 3'b111);
    req1 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_gnt", {gnt1, gnt0}, 0);
    chk("ar_sel_busy", {mux_sel, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1; m_data = 8'h00;
    @(negedge clk);
    rv = '{1, 1, 8'h5D, 8'hD5, 0, 0, 0, 8'h5D};
    do_txn(rv, "ar_tie");

    // HOLD_CYCLES=1 instance: capture after one settle cycle.
    @(negedge clk);
    b_i0 = 8'hFF; b_req0 = 1;
    @(negedge clk);
    chk("h1_settle", {b_valid, b_busy, b_sel}, 3'b010);
    @(negedge clk);
    chk("h1_valid", b_valid, 1);
    chk("h1_data", b_data, 8'hFF);
    chk("h1_gnt", {b_gnt1, b_gnt0, b_src}, 3'b010);
    b_req0 = 0; b_ready = 1;
    @(negedge clk);
    chk("h1_hs", {b_valid, b_busy}, 0);
    b_ready = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
